// File: rtl/rk4_datapath.sv
// rk4_datapath
//   Fixed-point RK4 iteration engine for dy/dt = -a*y with a = 2^-A_SHIFT and
//   step h = 2^-H_SHIFT. Each RK4 step takes five clock cycles. An internal
//   phase sequencer walks K1, K2, K3, K4 and UPD. The sequencer advances only
//   while SEL is high and LIMIT is low. After N_STEPS committed steps LIMIT
//   rises and the engine stops.
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   asynchronous active-high reset; aborts any partial step
//   SEL       in   1 = advance one phase per cycle, 0 = freeze
//   LD        in   latch the current y into Y_DISP (pre-update y in P_UPD)
//   LD_DISP   in   1 = DISP_DATA shows Y_DISP, 0 = DISP_DATA is zero
//   LIMIT     out  registered, high once STEP_CNT reaches N_STEPS
//   STEP_CNT  out  number of completed steps
//   Y_CUR     out  current state y_n
//   Y_DISP    out  latched result for the display logic
//   DISP_DATA out  combinational LD_DISP ? Y_DISP : 0
module rk4_datapath #(
    parameter int                       WIDTH   = 16,
    parameter int                       FRAC    = 8,
    parameter logic signed [WIDTH-1:0]  Y0      = 16'sh0100,
    parameter int                       A_SHIFT = 0,
    parameter int                       H_SHIFT = 3,
    parameter int                       N_STEPS = 8,
    localparam int                      CW      = $clog2(N_STEPS + 1)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    SEL,
    input  logic                    LD,
    input  logic                    LD_DISP,
    output logic                    LIMIT,
    output logic [CW-1:0]           STEP_CNT,
    output logic signed [WIDTH-1:0] Y_CUR,
    output logic signed [WIDTH-1:0] Y_DISP,
    output logic signed [WIDTH-1:0] DISP_DATA
);

    // k values carry two guard bits so that negating the derivative cannot
    // wrap. The weighted sum needs one more bit for the 2*k2 + 2*k3 terms.
    // The product width holds the sum multiplied by a FRAC+1 bit signed constant.
    localparam int KW = WIDTH + 2;
    localparam int SW = WIDTH + 3;
    localparam int PW = SW + FRAC + 1;

    // The value 1/6 in Q.FRAC, rounded toward the nearest value.
    localparam logic signed [PW-1:0] RECIP6 = PW'(((2 ** FRAC) + 3) / 6);

    typedef enum logic [2:0] {
        P_K1  = 3'd0,
        P_K2  = 3'd1,
        P_K3  = 3'd2,
        P_K4  = 3'd3,
        P_UPD = 3'd4
    } phase_t;

    phase_t                  phase_r;
    phase_t                  phase_next_s;
    logic signed [WIDTH-1:0] y_r;
    logic signed [WIDTH-1:0] y_disp_r;
    logic [CW-1:0]           step_cnt_r;
    logic                    limit_r;
    logic signed [KW-1:0]    k1_r;
    logic signed [KW-1:0]    k2_r;
    logic signed [KW-1:0]    k3_r;
    logic signed [KW-1:0]    k4_r;

    logic                    adv_s;
    logic                    ld_k1_s;
    logic                    ld_k2_s;
    logic                    ld_k3_s;
    logic                    ld_k4_s;
    logic                    upd_s;
    logic signed [KW-1:0]    y_ext_s;
    logic signed [KW-1:0]    arg_s;
    logic signed [KW-1:0]    k_new_s;
    logic signed [SW-1:0]    s_s;
    logic signed [PW-1:0]    s_ext_s;
    logic signed [PW-1:0]    y_pw_s;
    logic signed [PW-1:0]    prod_s;
    logic signed [WIDTH-1:0] y_upd_s;

    // Sign-extend a y-width value to the k width.
    function automatic logic signed [KW-1:0] sext_k(input logic signed [WIDTH-1:0] v);
        return {{(KW - WIDTH){v[WIDTH-1]}}, v};
    endfunction

    // Sign-extend a k-width value to the weighted-sum width.
    function automatic logic signed [SW-1:0] sext_s(input logic signed [KW-1:0] v);
        return {{(SW - KW){v[KW-1]}}, v};
    endfunction

    // The sequencer stops for good once LIMIT is high.
    assign adv_s = SEL & ~limit_r;

    // Phase state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase_r <= P_K1;
        end else begin
            phase_r <= phase_next_s;
        end
    end

    // Next-phase logic: advance one phase per enabled cycle, otherwise hold.
    always_comb begin
        phase_next_s = phase_r;
        case (phase_r)
            P_K1:    phase_next_s = adv_s ? P_K2  : P_K1;
            P_K2:    phase_next_s = adv_s ? P_K3  : P_K2;
            P_K3:    phase_next_s = adv_s ? P_K4  : P_K3;
            P_K4:    phase_next_s = adv_s ? P_UPD : P_K4;
            P_UPD:   phase_next_s = adv_s ? P_K1  : P_UPD;
            default: phase_next_s = P_K1;
        endcase
    end

    // Phase outputs: derivative argument and per-phase load strobes.
    always_comb begin
        y_ext_s = sext_k(y_r);
        arg_s   = y_ext_s;
        ld_k1_s = 1'b0;
        ld_k2_s = 1'b0;
        ld_k3_s = 1'b0;
        ld_k4_s = 1'b0;
        upd_s   = 1'b0;
        case (phase_r)
            P_K1: begin
                arg_s   = y_ext_s;
                ld_k1_s = adv_s;
            end
            P_K2: begin
                arg_s   = y_ext_s + (k1_r >>> (H_SHIFT + 1));
                ld_k2_s = adv_s;
            end
            P_K3: begin
                arg_s   = y_ext_s + (k2_r >>> (H_SHIFT + 1));
                ld_k3_s = adv_s;
            end
            P_K4: begin
                arg_s   = y_ext_s + (k3_r >>> H_SHIFT);
                ld_k4_s = adv_s;
            end
            P_UPD: begin
                arg_s   = y_ext_s;
                upd_s   = adv_s;
            end
            default: begin
                arg_s   = y_ext_s;
            end
        endcase
        // f(v) = -(v >>> A_SHIFT)
        k_new_s = -(arg_s >>> A_SHIFT);
    end

    // Update arithmetic. The shifts are floor shifts. The final add is kept at
    // full width and truncated to WIDTH only on the result.
    always_comb begin
        s_s     = sext_s(k1_r) + (sext_s(k2_r) <<< 1) + (sext_s(k3_r) <<< 1) + sext_s(k4_r);
        s_ext_s = $signed({{(PW - SW){s_s[SW-1]}}, s_s});
        y_pw_s  = $signed({{(PW - WIDTH){y_r[WIDTH-1]}}, y_r});
        prod_s  = (s_ext_s >>> H_SHIFT) * RECIP6;
        y_upd_s = WIDTH'(y_pw_s + (prod_s >>> FRAC));
    end

    // Datapath registers. LD samples y_r before the update in the same cycle,
    // so a load in P_UPD captures the pre-update value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            y_r        <= Y0;
            y_disp_r   <= {WIDTH{1'b0}};
            step_cnt_r <= {CW{1'b0}};
            limit_r    <= 1'b0;
            k1_r       <= {KW{1'b0}};
            k2_r       <= {KW{1'b0}};
            k3_r       <= {KW{1'b0}};
            k4_r       <= {KW{1'b0}};
        end else begin
            if (ld_k1_s) k1_r <= k_new_s;
            if (ld_k2_s) k2_r <= k_new_s;
            if (ld_k3_s) k3_r <= k_new_s;
            if (ld_k4_s) k4_r <= k_new_s;
            if (upd_s) begin
                y_r        <= y_upd_s;
                step_cnt_r <= step_cnt_r + CW'(1);
                limit_r    <= ((step_cnt_r + CW'(1)) == CW'(N_STEPS));
            end
            if (LD) y_disp_r <= y_r;
        end
    end

    assign LIMIT     = limit_r;
    assign STEP_CNT  = step_cnt_r;
    assign Y_CUR     = y_r;
    assign Y_DISP    = y_disp_r;
    assign DISP_DATA = LD_DISP ? y_disp_r : {WIDTH{1'b0}};

endmodule

// File: tb/tb_rk4_datapath.sv
// Directed testbench for rk4_datapath with the default parameters.
// Inputs change on the falling edge. Outputs are sampled on the falling edge,
// away from the active rising edge.
module tb_rk4_datapath;

    logic               CLK;
    logic               RST;
    logic               SEL;
    logic               LD;
    logic               LD_DISP;
    logic               LIMIT;
    logic [3:0]         STEP_CNT;
    logic signed [15:0] Y_CUR;
    logic signed [15:0] Y_DISP;
    logic signed [15:0] DISP_DATA;

    int n_checks;
    int n_fail;
    int y7_exp;
    int y8_exp;

    rk4_datapath dut (
        .CLK      (CLK),
        .RST      (RST),
        .SEL      (SEL),
        .LD       (LD),
        .LD_DISP  (LD_DISP),
        .LIMIT    (LIMIT),
        .STEP_CNT (STEP_CNT),
        .Y_CUR    (Y_CUR),
        .Y_DISP   (Y_DISP),
        .DISP_DATA(DISP_DATA)
    );

    // 10 ns clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model for y after n steps (a=1, h=1/8, FRAC=8, RECIP6=43).
    function automatic int rk4_model(input int steps);
        int y, k1, k2, k3, k4, s;
        y = 256;
        for (int i = 0; i < steps; i++) begin
            k1 = -y;
            k2 = -(y + (k1 >>> 4));
            k3 = -(y + (k2 >>> 4));
            k4 = -(y + (k3 >>> 3));
            s  = k1 + 2 * k2 + 2 * k3 + k4;
            y  = y + (((s >>> 3) * 43) >>> 8);
        end
        return y;
    endfunction

    // Hold SEL high for n rising edges, starting and ending on a falling edge.
    task automatic run_sel(input int n);
        SEL = 1'b1;
        repeat (n) @(negedge CLK);
        SEL = 1'b0;
    endtask

    // Synchronous-looking reset pulse, aligned to the falling edge.
    task automatic do_reset();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        y7_exp   = rk4_model(7);
        y8_exp   = rk4_model(8);
        RST      = 1'b1;
        SEL      = 1'b0;
        LD       = 1'b0;
        LD_DISP  = 1'b1;
        repeat (2) @(negedge CLK);

        // 1. reset state
        check_val("rst_y_cur",     int'($signed(Y_CUR)), 256);
        check_val("rst_y_disp",    int'($signed(Y_DISP)), 0);
        check_val("rst_step_cnt",  int'(STEP_CNT), 0);
        check_val("rst_limit",     int'(LIMIT), 0);
        check_val("rst_disp_data", int'($signed(DISP_DATA)), 0);
        LD_DISP = 1'b0;
        RST = 1'b0;
        @(negedge CLK);

        // 2. first step: no commit before P_UPD, then y=225
        run_sel(4);
        check_val("s1_partial_y",   int'($signed(Y_CUR)), 256);
        check_val("s1_partial_cnt", int'(STEP_CNT), 0);
        run_sel(1);
        check_val("s1_y",   int'($signed(Y_CUR)), 225);
        check_val("s1_cnt", int'(STEP_CNT), 1);
        run_sel(5);
        check_val("s2_y",   int'($signed(Y_CUR)), 198);
        check_val("s2_cnt", int'(STEP_CNT), 2);

        // 3. LIMIT exactly at SEL-high cycle 40 (10 used so far)
        run_sel(29);
        check_val("c39_limit", int'(LIMIT), 0);
        check_val("c39_cnt",   int'(STEP_CNT), 7);
        check_val("c39_y",     int'($signed(Y_CUR)), y7_exp);
        run_sel(1);
        check_val("c40_limit", int'(LIMIT), 1);
        check_val("c40_cnt",   int'(STEP_CNT), 8);
        check_val("c40_y",     int'($signed(Y_CUR)), y8_exp);
        run_sel(10);
        check_val("post_limit", int'(LIMIT), 1);
        check_val("post_cnt",   int'(STEP_CNT), 8);
        check_val("post_y",     int'($signed(Y_CUR)), y8_exp);
        LD = 1'b1;
        @(negedge CLK);
        LD = 1'b0;
        check_val("ld_after_limit", int'($signed(Y_DISP)), y8_exp);
        LD_DISP = 1'b1;
        #1;
        check_val("disp_on",  int'($signed(DISP_DATA)), y8_exp);
        LD_DISP = 1'b0;
        #1;
        check_val("disp_off", int'($signed(DISP_DATA)), 0);

        // 4. freeze after phase 2 of step 1
        do_reset();
        run_sel(2);
        SEL = 1'b0;
        repeat (7) @(negedge CLK);
        check_val("frz_y",   int'($signed(Y_CUR)), 256);
        check_val("frz_cnt", int'(STEP_CNT), 0);
        run_sel(2);
        check_val("frz_4hi_y", int'($signed(Y_CUR)), 256);
        run_sel(1);
        check_val("frz_5hi_y",   int'($signed(Y_CUR)), 225);
        check_val("frz_5hi_cnt", int'(STEP_CNT), 1);

        // 5. LD coincident with P_UPD captures pre-update y
        do_reset();
        run_sel(4);
        SEL = 1'b1;
        LD  = 1'b1;
        @(negedge CLK);
        SEL = 1'b0;
        LD  = 1'b0;
        check_val("ld_upd_disp", int'($signed(Y_DISP)), 256);
        check_val("ld_upd_y",    int'($signed(Y_CUR)), 225);
        LD = 1'b1;
        @(negedge CLK);
        LD = 1'b0;
        check_val("ld_idle_disp", int'($signed(Y_DISP)), 225);

        // 6. asynchronous reset during step 3 P_K4
        do_reset();
        run_sel(13);
        check_val("pre_rst_y",   int'($signed(Y_CUR)), 198);
        check_val("pre_rst_cnt", int'(STEP_CNT), 2);
        LD = 1'b1;
        @(negedge CLK);
        LD = 1'b0;
        check_val("pre_rst_disp", int'($signed(Y_DISP)), 198);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check_val("arst_y",     int'($signed(Y_CUR)), 256);
        check_val("arst_disp",  int'($signed(Y_DISP)), 0);
        check_val("arst_cnt",   int'(STEP_CNT), 0);
        check_val("arst_limit", int'(LIMIT), 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        run_sel(5);
        check_val("rerun_y",   int'($signed(Y_CUR)), 225);
        check_val("rerun_cnt", int'(STEP_CNT), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
